spi_cmd_decoder: RTL and testbench

SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

---
 rtl/spi_cmd_decoder.sv | 153 +++++++++++++++
 tb/tb_spi_cmd_decoder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: turns a latched 32-bit frame into one memory write, read or reply word.
// Define ILLEGAL_CMD_COUNT_EN to add the saturating err_count output.
module spi_cmd_decoder #(
  parameter int MEM_DEPTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable_n,
  input  logic        latch_data_n,
  input  logic [31:0] rx_word,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [15:0] mem_rdata,
  output logic [31:0] tx_word,
  output logic        tx_load,
  output logic        busy,
  output logic        cmd_err
`ifdef ILLEGAL_CMD_COUNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DECODE    = 3'd1,
    WRITE     = 3'd2,
    READ_REQ  = 3'd3,
    READ_CAPT = 3'd4,
    HOLD      = 3'd5
  } state_t;

  localparam logic [8:0] DEPTH_LIM  = (MEM_DEPTH > 256) ? 9'd256 : 9'(MEM_DEPTH);
  localparam logic [7:0] FLUSH_INIT = 8'(SYNC_STAGES);

  state_t                 state;
  logic [SYNC_STAGES-1:0] en_sync;
  logic [SYNC_STAGES-1:0] latch_sync;
  logic                   en_s;
  logic                   latch_s;
  logic                   latch_prev;
  logic                   latch_fall;
  logic [7:0]             flush_cnt;
  logic [31:0]            cmd_reg;
  logic [7:0]             cmd;
  logic [7:0]             addr;
  logic [15:0]            data;
  logic                   addr_ok;
  logic [7:0]             rx_cmd;
  logic                   rx_addr_ok;
  logic                   rx_bad;

  assign en_s       = en_sync[SYNC_STAGES-1];
  assign latch_s    = latch_sync[SYNC_STAGES-1];
  assign latch_fall = latch_prev & ~latch_s;
  assign busy       = (state != IDLE);

  assign cmd     = cmd_reg[31:24];
  assign addr    = cmd_reg[23:16];
  assign data    = cmd_reg[15:0];
  assign addr_ok = ({1'b0, addr} < DEPTH_LIM);

  // Error classification is done on the incoming frame so cmd_err lines up with DECODE.
  assign rx_cmd     = rx_word[31:24];
  assign rx_addr_ok = ({1'b0, rx_word[23:16]} < DEPTH_LIM);
  assign rx_bad     = !((rx_cmd == 8'h00) ||
                        (((rx_cmd == 8'h01) || (rx_cmd == 8'h02)) && rx_addr_ok));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      en_sync    <= '1;
      latch_sync <= '1;
      latch_prev <= 1'b0;
      flush_cnt  <= FLUSH_INIT;
      state      <= IDLE;
      cmd_reg    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      tx_word    <= '0;
      tx_load    <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      en_sync    <= {en_sync[SYNC_STAGES-2:0], enable_n};
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], latch_data_n};
      if (flush_cnt != 8'd0) flush_cnt <= flush_cnt - 8'd1;
      // Arm edge detection only once a real high level has crossed the synchronizer,
      // so a latch pin held low through reset never looks like a fresh falling edge.
      latch_prev <= (flush_cnt == 8'd0) & latch_s;

      mem_we  <= 1'b0;
      mem_re  <= 1'b0;
      tx_load <= 1'b0;
      cmd_err <= 1'b0;

      case (state)
        IDLE: begin
          if (latch_fall && !en_s) begin
            cmd_reg <= rx_word;
            cmd_err <= rx_bad;
            state   <= DECODE;
          end
        end
        DECODE: begin
          if (en_s) begin
            state <= IDLE;
          end else if ((cmd == 8'h02) && addr_ok) begin
            state     <= WRITE;
            mem_we    <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= data;
          end else if ((cmd == 8'h01) && addr_ok) begin
            state    <= READ_REQ;
            mem_re   <= 1'b1;
            mem_addr <= addr;
          end else begin
            state <= HOLD;
          end
        end
        WRITE:    state <= en_s ? IDLE : HOLD;
        READ_REQ: state <= en_s ? IDLE : READ_CAPT;
        READ_CAPT: begin
          if (en_s) begin
            state <= IDLE;
          end else begin
            tx_word <= {8'h01, addr, mem_rdata};
            tx_load <= 1'b1;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (en_s || latch_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ILLEGAL_CMD_COUNT_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      err_count <= 8'd0;
    end else if (cmd_err && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Bench for spi_cmd_decoder: directed scenarios plus randomized frames against a
// transaction-level model of expected memory writes, reads, replies and errors.
module tb_spi_cmd_decoder;

  localparam int S     = 2;
  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable_n;
  logic        latch_data_n;
  logic [31:0] rx_word;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [15:0] mem_rdata;
  logic [31:0] tx_word;
  logic        tx_load;
  logic        busy;
  logic        cmd_err;
`ifdef ILLEGAL_CMD_COUNT_EN
  logic [7:0]  err_count;
`endif

  spi_cmd_decoder #(.MEM_DEPTH(DEPTH), .SYNC_STAGES(S)) dut (
    .clock(clock), .reset_n(reset_n), .enable_n(enable_n), .latch_data_n(latch_data_n),
    .rx_word(rx_word), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata), .tx_word(tx_word), .tx_load(tx_load),
    .busy(busy), .cmd_err(cmd_err)
`ifdef ILLEGAL_CMD_COUNT_EN
    , .err_count(err_count)
`endif
  );

  // ---------------- clock / reset / environment ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [15:0] env_mem[256];
  always @(posedge clock) begin
    if (mem_we) env_mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem_re ? env_mem[mem_addr] : 16'($urandom);
  end

  // ---------------- model and scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] model_mem[256];
  logic [23:0] exp_wr_q[$];
  logic [7:0]  exp_rd_q[$];
  logic [31:0] exp_tx_q[$];
  int          err_exp = 0;
  int          err_seen = 0;
  int          model_err = 0;
  logic [31:0] model_tx = '0;
  int          fall_cyc = 0;
  logic        mon_en = 1'b0;
  logic        abort_win = 1'b0;
  int          ab_we = 0, ab_re = 0, ab_tl = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_rng(input string name, input int v, input int lo, input int hi);
    checks++;
    if (v < lo || v > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, v, lo, hi);
    end
  endtask

  // What one accepted frame must produce, straight from the command table.
  task automatic predict(input logic [31:0] w);
    logic [7:0] c, a;
    c = w[31:24];
    a = w[23:16];
    if (c == 8'h02 && int'(a) < DEPTH) begin
      exp_wr_q.push_back(w[23:0]);
      model_mem[a] = w[15:0];
    end else if (c == 8'h01 && int'(a) < DEPTH) begin
      exp_rd_q.push_back(a);
      exp_tx_q.push_back({8'h01, a, model_mem[a]});
    end else if (c != 8'h00) begin
      err_exp++;
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && mon_en) begin
      check("strobe_excl", 32'(int'(mem_we) + int'(mem_re) + int'(tx_load) <= 1), 32'd1);
`ifdef ILLEGAL_CMD_COUNT_EN
      check("err_count", {24'd0, err_count}, 32'(model_err));
`endif
      if (mem_we) begin
        if (abort_win) ab_we++;
        else if (exp_wr_q.size() == 0) check("unexpected_we", 32'd1, 32'd0);
        else begin
          check("we_addr_data", {8'd0, mem_addr, mem_wdata}, {8'd0, exp_wr_q.pop_front()});
          check_rng("we_latency", cyc - fall_cyc, S + 2, S + 4);
        end
      end
      if (mem_re) begin
        if (abort_win) ab_re++;
        else if (exp_rd_q.size() == 0) check("unexpected_re", 32'd1, 32'd0);
        else check("re_addr", {24'd0, mem_addr}, {24'd0, exp_rd_q.pop_front()});
      end
      if (tx_load) begin
        if (abort_win) ab_tl++;
        else if (exp_tx_q.size() == 0) check("unexpected_tx_load", 32'd1, 32'd0);
        else begin
          model_tx = exp_tx_q.pop_front();
          check_rng("tx_latency", cyc - fall_cyc, S + 3, S + 5);
        end
      end
      check("tx_word", tx_word, model_tx);
      if (cmd_err) begin
        err_seen++;
        if (err_exp == 0) check("unexpected_cmd_err", 32'd1, 32'd0);
        else begin
          err_exp--;
          if (model_err < 255) model_err++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic begin_cmd(input logic en_n, input logic [31:0] w);
    enable_n = en_n;
    rx_word  = w;
    repeat (S + 2) tick();
    latch_data_n = 1'b0;
    fall_cyc = cyc;
    if (!en_n) predict(w);
  endtask

  task automatic end_cmd(input int gap);
    latch_data_n = 1'b1;
    repeat (gap) tick();
    check("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic cmd_pulse(input logic en_n, input logic [31:0] w, input int low, input int gap);
    begin_cmd(en_n, w);
    repeat (low) tick();
    end_cmd(gap);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_re"}, {31'd0, mem_re}, 32'd0);
    check({tag, "_tx_load"}, {31'd0, tx_load}, 32'd0);
    check({tag, "_cmd_err"}, {31'd0, cmd_err}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_addr"}, {24'd0, mem_addr}, 32'd0);
    check({tag, "_wdata"}, {16'd0, mem_wdata}, 32'd0);
    check({tag, "_tx_word"}, tx_word, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] w;
    logic [7:0]  c, a;
    int          r, e0, seen;

    for (int i = 0; i < 256; i++) begin
      env_mem[i]   = 16'($urandom);
      model_mem[i] = env_mem[i];
    end
    env_mem[3] = 16'hAAAA;
    model_mem[3] = 16'hAAAA;

    reset_n = 1'b0; enable_n = 1'b1; latch_data_n = 1'b1; rx_word = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
`ifdef ILLEGAL_CMD_COUNT_EN
    check("reset_err_count", {24'd0, err_count}, 32'd0);
`endif
    reset_n = 1'b1;
    repeat (S + 3) tick();
    mon_en = 1'b1;

    // Write: long pulse, exactly one strobe, busy held until the latch rises.
    begin_cmd(1'b0, 32'h0200FACE);
    repeat (50) tick();
    check("write_busy_mid", {31'd0, busy}, 32'd1);
    repeat (50) tick();
    end_cmd(S + 10);
    check("write_mem0", {16'd0, env_mem[0]}, 32'h0000FACE);

    // Read of word 3.
    cmd_pulse(1'b0, 32'h01030000, 10, S + 12);
    check("read_tx_literal", tx_word, 32'h0103AAAA);

    // Illegal command and out-of-range address.
    e0 = err_seen;
    cmd_pulse(1'b0, 32'h7F001234, 8, S + 12);
    cmd_pulse(1'b0, 32'h02201234, 8, S + 12);
    check("illegal_pulses", 32'(err_seen - e0), 32'd2);
`ifdef ILLEGAL_CMD_COUNT_EN
    check("illegal_err_count", {24'd0, err_count}, 32'd2);
`endif

    // Chip disabled during the pulse: nothing may happen.
    begin_cmd(1'b1, 32'h02051111);
    repeat (S + 4) tick();
    check("disabled_busy", {31'd0, busy}, 32'd0);
    repeat (4) tick();
    end_cmd(S + 10);

    // Enable dropped so the synchronized copy rises while the read request is out.
    enable_n = 1'b0;
    rx_word  = 32'h01050000;
    repeat (S + 2) tick();
    abort_win = 1'b1;
    latch_data_n = 1'b0;
    tick();
    tick();
    enable_n = 1'b1;
    repeat (4) tick();
    latch_data_n = 1'b1;
    repeat (S + 12) tick();
    abort_win = 1'b0;
    check("abort_tx_load", 32'(ab_tl), 32'd0);
    check("abort_we", 32'(ab_we), 32'd0);
    check("abort_re_at_most_one", 32'(ab_re <= 1), 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);

    // Second falling edge arriving while the first read is still being served.
    begin_cmd(1'b0, 32'h01030000);
    repeat (2) tick();
    latch_data_n = 1'b1;
    repeat (2) tick();
    latch_data_n = 1'b0;
    repeat (10) tick();
    end_cmd(S + 12);
    check("hold_ignore_tx", tx_word, 32'h0103AAAA);

    // Randomized frames.
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(DEPTH, 255))
                                      : 8'($urandom_range(0, DEPTH - 1));
      if (r <= 3) c = 8'h02;
      else if (r <= 6) c = 8'h01;
      else if (r == 7) begin c = 8'h00; a = 8'($urandom_range(0, DEPTH - 1)); end
      else c = 8'($urandom_range(3, 255));
      w = {c, a, 16'($urandom)};
      cmd_pulse(($urandom_range(0, 5) == 0), w, $urandom_range(2, 30), $urandom_range(S + 10, S + 20));
    end

    // Reset while the write strobe is out; latch pin stays low across release.
    begin_cmd(1'b0, 32'h0205BEEF);
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      @(negedge clock);
      if (mem_we) seen = 1;
    end
    check("reset_test_we_seen", 32'(seen), 32'd1);
    #1;
    reset_n = 1'b0;
    model_tx = '0;
    model_err = 0;
    @(posedge clock);
    #1;
    check_reset_outputs("midcmd_reset");
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (20) tick();
    check("held_low_no_cmd_busy", {31'd0, busy}, 32'd0);
    end_cmd(S + 10);
    cmd_pulse(1'b0, 32'h01050000, 6, S + 12);
    check("post_reset_read", tx_word, 32'h0105BEEF);

    check("wr_q_empty", 32'(exp_wr_q.size()), 32'd0);
    check("rd_q_empty", 32'(exp_rd_q.size()), 32'd0);
    check("tx_q_empty", 32'(exp_tx_q.size()), 32'd0);
    check("err_pending", 32'(err_exp), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
